// File: rtl/fetch_decode_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_decode_sequencer
//
// Fetches one instruction word per request over a req/ack memory port and
// latches it with its PC. It classifies the opcode into a one-hot encoding
// type and hands inst/pc/type to the extract unit over a valid/ready
// handshake. It also handles control-flow redirects and memory ack timeouts.
//
// Optional feature macro: FETCH_ILLEGAL_TRAP_EN
//   defined   : a captured word with an unrecognised opcode or inst[1:0]!=2'b11
//               raises illegal with dec_valid. After it is consumed, the
//               sequencer parks in TRAP until a redirect or reset arrives.
//   undefined : illegal is tied low. Unrecognised words pass with dec_en=0.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   mem_req/mem_addr      fetch request; held with a stable address until ack
//   mem_ack/mem_rdata     fetch completion and instruction word
//   redirect/redirect_pc  single-cycle control-flow redirect and new PC
//   dec_valid/dec_ready   handshake to the decode stage
//   dec_inst/dec_pc       latched instruction and its PC
//   dec_en                one-hot {J,U,B,S,I,R}; 0 means unrecognised
//   fetch_fault           sticky ack-timeout indication
//   illegal               unrecognised-instruction flag
// ----------------------------------------------------------------------------
module fetch_decode_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [5:0]  dec_en,
    output logic        fetch_fault,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_VALID,
        S_DISCARD,
        S_FAULT,
        S_TRAP
    } state_t;

    localparam logic [31:0] TIMEOUT_LIM = ACK_TIMEOUT;

    function automatic logic [5:0] decode_en(input logic [6:0] op);
        case (op)
            7'b0110011: decode_en = 6'b000001;                 // R
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b1110011: decode_en = 6'b000010;     // I
            7'b0100011: decode_en = 6'b000100;                 // S
            7'b1100011: decode_en = 6'b001000;                 // B
            7'b0110111, 7'b0010111: decode_en = 6'b010000;     // U
            7'b1101111: decode_en = 6'b100000;                 // J
            default:    decode_en = 6'b000000;
        endcase
    endfunction

    state_t      state, state_n;
    logic [31:0] pc, pc_n;        // address of the current / outstanding fetch
    logic [31:0] pend, pend_n;    // redirect target held while DISCARD drains
    logic [31:0] cnt, cnt_n;      // cycles spent waiting for mem_ack
    logic [31:0] inst_q, inst_n;
    logic [31:0] dpc_q, dpc_n;
    logic [5:0]  en_q, en_n;
    logic [31:0] redir_tgt;
    logic [31:0] cnt_inc;
    logic        timeout_hit;
    logic [5:0]  cap_en;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic        ill_q, ill_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            pend   <= 32'h0;
            cnt    <= 32'h0;
            inst_q <= 32'h0;
            dpc_q  <= 32'h0;
            en_q   <= 6'h0;
`ifdef FETCH_ILLEGAL_TRAP_EN
            ill_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            pend   <= pend_n;
            cnt    <= cnt_n;
            inst_q <= inst_n;
            dpc_q  <= dpc_n;
            en_q   <= en_n;
`ifdef FETCH_ILLEGAL_TRAP_EN
            ill_q  <= ill_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pend_n    = pend;
        cnt_n     = cnt;
        inst_n    = inst_q;
        dpc_n     = dpc_q;
        en_n      = en_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
        ill_n     = ill_q;
`endif
        redir_tgt   = redirect_pc & 32'hFFFF_FFFC;
        cnt_inc     = cnt + 32'd1;
        timeout_hit = (ACK_TIMEOUT != 0) && (cnt_inc == TIMEOUT_LIM);
        cap_en      = decode_en(mem_rdata[6:0]);

        case (state)
            S_FETCH: begin
                if (redirect) begin
                    cnt_n = 32'h0;
                    if (mem_ack) begin
                        // Request already completed: drop the word, refetch at target.
                        pc_n = redir_tgt;
                    end else begin
                        // Request cannot be withdrawn; drain it in DISCARD.
                        pend_n  = redir_tgt;
                        state_n = S_DISCARD;
                    end
                end else if (mem_ack) begin
                    cnt_n   = 32'h0;
                    inst_n  = mem_rdata;
                    dpc_n   = pc;
                    en_n    = cap_en;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    ill_n   = (cap_en == 6'h0) || (mem_rdata[1:0] != 2'b11);
`endif
                    state_n = S_VALID;
                end else if (timeout_hit) begin
                    cnt_n   = 32'h0;
                    state_n = S_FAULT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            S_VALID: begin
                // A redirect wins even if the handshake completes this cycle.
                if (redirect) begin
                    pc_n    = redir_tgt;
                    state_n = S_FETCH;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    ill_n   = 1'b0;
`endif
                end else if (dec_ready) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
                    if (ill_q) begin
                        state_n = S_TRAP;
                    end else begin
                        pc_n    = pc + 32'd4;
                        state_n = S_FETCH;
                    end
`else
                    pc_n    = pc + 32'd4;
                    state_n = S_FETCH;
`endif
                end
            end

            S_DISCARD: begin
                if (redirect) begin
                    cnt_n  = 32'h0;
                    pend_n = redir_tgt;
                    if (mem_ack) begin
                        pc_n    = redir_tgt;
                        state_n = S_FETCH;
                    end
                end else if (mem_ack) begin
                    cnt_n   = 32'h0;
                    pc_n    = pend;
                    state_n = S_FETCH;
                end else if (timeout_hit) begin
                    cnt_n   = 32'h0;
                    state_n = S_FAULT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            S_FAULT, S_TRAP: begin
                // Parked; late acks ignored until a redirect restarts fetch.
                cnt_n = 32'h0;
                if (redirect) begin
                    pc_n    = redir_tgt;
                    state_n = S_FETCH;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    ill_n   = 1'b0;
`endif
                end
            end

            default: state_n = S_FETCH;
        endcase

        // Outputs are forced low while reset is asserted.
        mem_req     = !reset && ((state == S_FETCH) || (state == S_DISCARD));
        mem_addr    = reset ? 32'h0 : pc;
        dec_valid   = !reset && (state == S_VALID);
        dec_inst    = reset ? 32'h0 : inst_q;
        dec_pc      = reset ? 32'h0 : dpc_q;
        dec_en      = reset ? 6'h0 : en_q;
        fetch_fault = !reset && (state == S_FAULT);
`ifdef FETCH_ILLEGAL_TRAP_EN
        illegal     = !reset && ill_q;
`else
        illegal     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_decode_sequencer
//
// Directed bench for fetch_decode_sequencer with default parameters
// (RESET_PC=0, ACK_TIMEOUT=16). A decode table drives the main function, and
// hand-written sequences cover redirects, timeout, wrap and reset corners.
// ----------------------------------------------------------------------------
module tb_fetch_decode_sequencer;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [5:0]  dec_en;
    logic        fetch_fault;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    fetch_decode_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .dec_en      (dec_en),
        .fetch_fault (fetch_fault),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [5:0]  en;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, hold ack off for lat cycles, then ack once.
    task automatic fetch_one(input logic [31:0] data, input int lat);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (mem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_req: mem_req %b after %0d cycles, expected 1", mem_req, n);
        end
        repeat (lat) step();
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack   = 1'b0;
    endtask

    task automatic consume();
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;

        vecs[0] = '{32'h0000_0033, 6'b000001};   // add   R
        vecs[1] = '{32'h0050_0093, 6'b000010};   // addi  I
        vecs[2] = '{32'h0000_2003, 6'b000010};   // lw    I
        vecs[3] = '{32'h0000_8067, 6'b000010};   // jalr  I
        vecs[4] = '{32'h0000_0073, 6'b000010};   // ecall I
        vecs[5] = '{32'h0000_2023, 6'b000100};   // sw    S
        vecs[6] = '{32'h0000_0063, 6'b001000};   // beq   B
        vecs[7] = '{32'h0000_00B7, 6'b010000};   // lui   U
        vecs[8] = '{32'h0000_0097, 6'b010000};   // auipc U
        vecs[9] = '{32'h0000_006F, 6'b100000};   // jal   J

        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_fetch_fault", fetch_fault, 0);
        check("rst_illegal", illegal, 0);
        check("rst_dec_en", dec_en, 0);
        reset = 1'b0;
        #1;
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, 32'h0);

        // 1: ack two cycles after request
        fetch_one(32'h0050_0093, 2);
        check("t1_valid", dec_valid, 1);
        check("t1_en", dec_en, 6'b000010);
        check("t1_pc", dec_pc, 32'h0);
        check("t1_inst", dec_inst, 32'h0050_0093);
        check("t1_req_low", mem_req, 0);
        consume();
        check("t1_next_req", mem_req, 1);
        check("t1_next_addr", mem_addr, 32'h4);

        // 2: decode stalls for five cycles
        fetch_one(32'h0000_2023, 0);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_inst", dec_inst, 32'h0000_2023);
            check("t2_hold_pc", dec_pc, 32'h4);
            check("t2_hold_valid", dec_valid, 1);
            check("t2_hold_noreq", mem_req, 0);
            step();
        end
        check("t2_hold_en", dec_en, 6'b000100);
        consume();
        check("t2_next_addr", mem_addr, 32'h8);

        // 3: redirect while request at 8 is outstanding
        step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("t3_discard_req", mem_req, 1);
        check("t3_discard_addr", mem_addr, 32'h8);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        mem_ack = 1'b0;
        check("t3_dropped", dec_valid, 0);
        check("t3_req", mem_req, 1);
        check("t3_addr", mem_addr, 32'h100);

        // Decode table
        exp_pc = 32'h100;
        for (int i = 0; i < 10; i++) begin
            fetch_one(vecs[i].rdata, i % 3);
            check("tbl_valid", dec_valid, 1);
            check("tbl_en", dec_en, vecs[i].en);
            check("tbl_pc", dec_pc, exp_pc);
            check("tbl_inst", dec_inst, vecs[i].rdata);
            check("tbl_illegal", illegal, 0);
            consume();
            exp_pc = exp_pc + 32'd4;
        end
        check("tbl_last_addr", mem_addr, 32'h128);

        // 4: handshake and redirect in the same cycle
        fetch_one(32'h0000_0013, 1);
        check("t4_pc", dec_pc, 32'h128);
        dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        dec_ready = 1'b0; redirect = 1'b0;
        check("t4_valid_low", dec_valid, 0);
        check("t4_addr", mem_addr, 32'h40);
        fetch_one(32'h0000_0013, 0);
        check("t4b_pc", dec_pc, 32'h40);
        redirect = 1'b1; redirect_pc = 32'h43;
        step();
        redirect = 1'b0;
        check("t4b_valid_low", dec_valid, 0);
        check("t4b_addr_aligned", mem_addr, 32'h40);
        // ack and redirect together in FETCH
        mem_ack = 1'b1; mem_rdata = 32'h0000_0033; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        mem_ack = 1'b0; redirect = 1'b0;
        check("t4c_dropped", dec_valid, 0);
        check("t4c_req", mem_req, 1);
        check("t4c_addr", mem_addr, 32'h200);

        // DISCARD keeps the newest redirect target
        redirect = 1'b1; redirect_pc = 32'h500;
        step();
        redirect_pc = 32'h600;
        step();
        redirect = 1'b0;
        check("disc_old_addr", mem_addr, 32'h200);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("disc_dropped", dec_valid, 0);
        check("disc_new_addr", mem_addr, 32'h600);

        // 5: ack withheld until timeout
        repeat (15) step();
        check("t5_no_fault_yet", fetch_fault, 0);
        check("t5_req_still", mem_req, 1);
        step();
        check("t5_fault", fetch_fault, 1);
        check("t5_req_low", mem_req, 0);
        check("t5_valid_low", dec_valid, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("t5_late_ack_fault", fetch_fault, 1);
        check("t5_late_ack_valid", dec_valid, 0);
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        check("t5_cleared", fetch_fault, 0);
        check("t5_req", mem_req, 1);
        check("t5_addr", mem_addr, 32'h300);

        // 6: unrecognised word
        fetch_one(32'hFFFF_FFFF, 0);
        check("t6_valid", dec_valid, 1);
        check("t6_en", dec_en, 6'b000000);
`ifdef FETCH_ILLEGAL_TRAP_EN
        check("t6_illegal", illegal, 1);
        consume();
        for (int i = 0; i < 3; i++) begin
            check("t6_trap_noreq", mem_req, 0);
            check("t6_trap_novalid", dec_valid, 0);
            check("t6_trap_illegal", illegal, 1);
            step();
        end
        redirect = 1'b1; redirect_pc = 32'h304;
        step();
        redirect = 1'b0;
        check("t6_illegal_clear", illegal, 0);
        check("t6_addr", mem_addr, 32'h304);
`else
        check("t6_illegal", illegal, 0);
        consume();
        check("t6_req", mem_req, 1);
        check("t6_addr", mem_addr, 32'h304);
`endif

        // PC wrap at the top of the address space
        mem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        mem_ack = 1'b0; redirect = 1'b0;
        check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        fetch_one(32'h0000_0013, 0);
        check("wrap_pc", dec_pc, 32'hFFFF_FFFC);
        consume();
        check("wrap_next", mem_addr, 32'h0);
        check("wrap_fault", fetch_fault, 0);

        // Reset while a request is outstanding
        step();
        reset = 1'b1;
        step();
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_valid", dec_valid, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_req_after", mem_req, 1);
        check("mid_rst_addr", mem_addr, 32'h0);
        fetch_one(32'h0000_0033, 1);
        check("mid_rst_en", dec_en, 6'b000001);
        check("mid_rst_pc", dec_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
